// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage definitions: store funct3 encodings, the store-queue
// FSM state type and the packed queue-entry layout.
package riscv_mem_pkg;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic [1:0] {
    SQ_IDLE   = 2'd0,  // queue empty
    SQ_ACTIVE = 2'd1,  // queue holds at least one store
    SQ_FLUSH  = 2'd2   // draining for a fence, new stores refused
  } sq_state_e;

  // One queued store: word address, byte enables and lane-replicated data.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sq_entry_t;

endpackage

// File: rtl/store_queue_ctrl_if.sv
// Pipeline-side and memory-side signals of the store queue. The controller
// connects through the slave modport; the pipeline/memory side uses master.
interface store_queue_ctrl_if;

  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  logic        flush_req;
  logic        flush_done;

  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        st_err;

  modport master (
    output st_valid, st_funct3, st_addr, st_data, ld_valid, ld_addr, flush_req,
    input  st_ready, ld_hazard, flush_done, dmem_we, dmem_be, dmem_addr,
           dmem_wdata, st_err
  );

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, ld_valid, ld_addr, flush_req,
    output st_ready, ld_hazard, flush_done, dmem_we, dmem_be, dmem_addr,
           dmem_wdata, st_err
  );

endinterface

// File: rtl/store_lane_fmt.sv
// Store lane formatter: turns a raw store (funct3, byte address, rs2) into a
// queue entry with byte enables and lane-replicated write data.
// Optional feature: define STORE_MISALIGN_TRAP_EN to reject misaligned SH/SW;
// otherwise the low address bits are ignored and the access is force-aligned.
module store_lane_fmt
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output sq_entry_t   entry,
  output logic        ok
);

  // Decode width and build byte enables / replicated data.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned and infer a latch.
    entry.waddr = addr[31:2];
    entry.be    = 4'b0000;
    entry.wdata = data;
    ok          = 1'b0;
    case (funct3)
      FUNCT3_SB: begin
        entry.be    = 4'b0001 << addr[1:0];
        entry.wdata = {4{data[7:0]}};
        ok          = 1'b1;
      end
      FUNCT3_SH: begin
        entry.be    = 4'b0011 << {addr[1], 1'b0};
        entry.wdata = {2{data[15:0]}};
`ifdef STORE_MISALIGN_TRAP_EN
        ok          = !addr[0];
`else
        ok          = 1'b1;
`endif
      end
      FUNCT3_SW: begin
        entry.be    = 4'b1111;
        entry.wdata = data;
`ifdef STORE_MISALIGN_TRAP_EN
        ok          = (addr[1:0] == 2'b00);
`else
        ok          = 1'b1;
`endif
      end
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_queue_ctrl.sv
// Store queue controller: buffers MEM-stage stores in a small FIFO and drains
// them to data memory whenever the load path does not need the port. Loads
// hitting a queued word are stalled via ld_hazard; flush_req drains the queue
// and answers with a one-cycle flush_done.
// Optional feature: STORE_MISALIGN_TRAP_EN (see store_lane_fmt).
module store_queue_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  store_queue_ctrl_if.slave  sq
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

  sq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  sq_state_e        state;
  logic             flush_done_q;
  logic             st_err_q;

  sq_entry_t        fmt_entry;
  logic             fmt_ok;
  logic             st_ready_w;
  logic             hit;
  logic             accept;
  logic             push;
  logic             pop;
  logic             load_owns;
  logic             unused_ld_lsb;

  store_lane_fmt u_fmt (
    .funct3 (sq.st_funct3),
    .addr   (sq.st_addr),
    .data   (sq.st_data),
    .entry  (fmt_entry),
    .ok     (fmt_ok)
  );

  assign st_ready_w    = (count < DEPTH_C) && (state != SQ_FLUSH);
  assign accept        = sq.st_valid && st_ready_w;
  assign push          = accept && fmt_ok;
  assign unused_ld_lsb = ^sq.ld_addr[1:0];

  // Word-address match of the load against every occupied queue slot.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - head} < count) && (mem[i].waddr == sq.ld_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign sq.ld_hazard = sq.ld_valid && hit;

  // Port arbitration: a hazard-free load wins unless a flush is draining.
  assign load_owns = sq.ld_valid && !sq.ld_hazard && (state != SQ_FLUSH);
  assign pop       = (count != '0) && !load_owns;

  assign sq.st_ready   = st_ready_w;
  assign sq.dmem_we    = pop;
  assign sq.dmem_be    = pop ? mem[head].be : 4'b0000;
  assign sq.dmem_wdata = mem[head].wdata;
  assign sq.dmem_addr  = load_owns ? {sq.ld_addr[31:2], 2'b00} : {mem[head].waddr, 2'b00};
  assign sq.flush_done = flush_done_q;
  assign sq.st_err     = st_err_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PTR_W + 1)'(1);
      2'b01:   count_nxt = count - (PTR_W + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Queue storage write at the tail.
  always_ff @(posedge clk) begin
    // NOTE: entry storage is deliberately not reset; count and the pointers
    // define which slots are live, so clearing them discards the contents.
    if (push) mem[tail] <= fmt_entry;
  end

  // Control FSM with pointers, count and registered pulse outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state        <= SQ_IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      flush_done_q <= 1'b0;
      st_err_q     <= 1'b0;
    end else begin
      st_err_q     <= accept && !fmt_ok;
      flush_done_q <= 1'b0;
      count        <= count_nxt;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case (state)
        SQ_IDLE, SQ_ACTIVE: begin
          if (sq.flush_req) begin
            if (count_nxt == '0) begin
              state        <= SQ_IDLE;
              flush_done_q <= 1'b1;
            end else begin
              state <= SQ_FLUSH;
            end
          end else begin
            state <= (count_nxt == '0) ? SQ_IDLE : SQ_ACTIVE;
          end
        end
        SQ_FLUSH: begin
          if (count_nxt == '0) begin
            state        <= SQ_IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state <= SQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Directed bench for store_queue_ctrl (DEPTH=2). Memory writes are checked by
// a scoreboard: expected writes are queued with the stimulus and a negedge
// monitor pops and compares each write the DUT presents. Pulses and stall
// outputs are checked directly in the stimulus flow.
module tb_store_queue_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } wr_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;

  store_queue_ctrl_if sq ();

  store_queue_ctrl #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_t w;
    w.addr  = a;
    w.be    = b;
    w.wdata = d;
    exp_q.push_back(w);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    check("st_ready_before_store", 32'(sq.st_ready), 32'd1);
    sq.st_valid  = 1'b1;
    sq.st_funct3 = f3;
    sq.st_addr   = a;
    sq.st_data   = d;
    tick();
    sq.st_valid  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every write the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (!rst && sq.dmem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%08h be %b, expected no write at %0t",
                 sq.dmem_addr, sq.dmem_be, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", sq.dmem_addr, mon_e.addr);
        check("wr_be", 32'(sq.dmem_be), 32'(mon_e.be));
        check("wr_wdata", sq.dmem_wdata, mon_e.wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    sq.st_valid  = 1'b0;
    sq.st_funct3 = 3'b000;
    sq.st_addr   = 32'h0;
    sq.st_data   = 32'h0;
    sq.ld_valid  = 1'b0;
    sq.ld_addr   = 32'h0;
    sq.flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_st_ready",   32'(sq.st_ready),   32'd1);
    check("rst_ld_hazard",  32'(sq.ld_hazard),  32'd0);
    check("rst_dmem_we",    32'(sq.dmem_we),    32'd0);
    check("rst_flush_done", 32'(sq.flush_done), 32'd0);
    check("rst_st_err",     32'(sq.st_err),     32'd0);

    // SB to byte 3 and SH to upper half, back to back (push and pop overlap)
    push_exp(32'h0000_0100, 4'b1000, 32'hDDDD_DDDD);
    push_exp(32'h0000_0200, 4'b1100, 32'h1234_1234);
    store(3'b000, 32'h0000_0103, 32'hAABB_CCDD);
    store(3'b001, 32'h0000_0202, 32'h0000_1234);
    check("legal_no_err", 32'(sq.st_err), 32'd0);
    wait_drain("drain_sb_sh");

    // SW and SB to lane 1
    push_exp(32'h0000_0300, 4'b1111, 32'hCAFE_BABE);
    push_exp(32'h0000_0000, 4'b0010, 32'h5555_5555);
    store(3'b010, 32'h0000_0300, 32'hCAFE_BABE);
    store(3'b000, 32'h0000_0001, 32'h0000_0055);
    wait_drain("drain_sw_sb");

    // Illegal funct3 values: consumed, error pulse, nothing written
    store(3'b011, 32'h0000_0500, 32'h0000_0001);
    check("illegal3_err",   32'(sq.st_err),  32'd1);
    check("illegal3_no_we", 32'(sq.dmem_we), 32'd0);
    store(3'b100, 32'h0000_0504, 32'h0000_0002);
    check("illegal4_err",   32'(sq.st_err),  32'd1);
    tick();
    check("err_pulse_end",  32'(sq.st_err),  32'd0);

    // Full queue while a hazard-free load holds the port
    sq.ld_valid = 1'b1;
    sq.ld_addr  = 32'h0000_0803;
    push_exp(32'h0000_0010, 4'b1111, 32'h0101_0101);
    push_exp(32'h0000_0014, 4'b1111, 32'h0202_0202);
    store(3'b010, 32'h0000_0010, 32'h0101_0101);
    store(3'b010, 32'h0000_0014, 32'h0202_0202);
    check("full_st_ready",  32'(sq.st_ready),  32'd0);
    check("full_no_hazard", 32'(sq.ld_hazard), 32'd0);
    check("load_we",        32'(sq.dmem_we),   32'd0);
    check("load_addr",      sq.dmem_addr,      32'h0000_0800);
    sq.st_valid  = 1'b1;
    sq.st_funct3 = 3'b010;
    sq.st_addr   = 32'h0000_0018;
    sq.st_data   = 32'h0303_0303;
    tick();
    check("third_stalled",  32'(sq.st_ready),  32'd0);
    sq.st_valid = 1'b0;
    sq.ld_valid = 1'b0;
    wait_drain("drain_full");

    // Load hazard on a queued word lasts until that word drains
    sq.ld_valid = 1'b1;
    sq.ld_addr  = 32'h0000_0900;
    push_exp(32'h0000_0040, 4'b1111, 32'h1122_3344);
    push_exp(32'h0000_0044, 4'b1111, 32'h5566_7788);
    store(3'b010, 32'h0000_0040, 32'h1122_3344);
    store(3'b010, 32'h0000_0044, 32'h5566_7788);
    sq.ld_addr = 32'h0000_0042;
    #1;
    check("hazard_on",      32'(sq.ld_hazard), 32'd1);
    check("hazard_drain",   32'(sq.dmem_we),   32'd1);
    check("hazard_addr",    sq.dmem_addr,      32'h0000_0040);
    tick();
    check("hazard_off",     32'(sq.ld_hazard), 32'd0);
    check("hazard_load_we", 32'(sq.dmem_we),   32'd0);
    check("hazard_ld_addr", sq.dmem_addr,      32'h0000_0040);
    sq.ld_valid = 1'b0;
    wait_drain("drain_hazard");

    // Flush with two entries, load held to show the drain overrides it
    sq.ld_valid = 1'b1;
    sq.ld_addr  = 32'h0000_0900;
    push_exp(32'h0000_0060, 4'b1111, 32'h6060_6060);
    push_exp(32'h0000_0064, 4'b1111, 32'h6464_6464);
    store(3'b010, 32'h0000_0060, 32'h6060_6060);
    store(3'b010, 32'h0000_0064, 32'h6464_6464);
    sq.flush_req = 1'b1;
    tick();
    sq.flush_req = 1'b0;
    check("flush_ready0",   32'(sq.st_ready),   32'd0);
    check("flush_drain1",   32'(sq.dmem_we),    32'd1);
    check("flush_no_done1", 32'(sq.flush_done), 32'd0);
    tick();
    check("flush_ready1",   32'(sq.st_ready),   32'd0);
    check("flush_drain2",   32'(sq.dmem_we),    32'd1);
    check("flush_no_done2", 32'(sq.flush_done), 32'd0);
    tick();
    check("flush_done",     32'(sq.flush_done), 32'd1);
    check("flush_ready_back", 32'(sq.st_ready), 32'd1);
    check("flush_load_we",  32'(sq.dmem_we),    32'd0);
    tick();
    check("flush_done_end", 32'(sq.flush_done), 32'd0);
    check("flush_empty",    32'(exp_q.size()),  32'd0);
    sq.ld_valid = 1'b0;

    // Flush with an empty queue
    sq.flush_req = 1'b1;
    tick();
    sq.flush_req = 1'b0;
    check("empty_flush_done",  32'(sq.flush_done), 32'd1);
    tick();
    check("empty_flush_pulse", 32'(sq.flush_done), 32'd0);

    // Misaligned SW and SH
`ifdef STORE_MISALIGN_TRAP_EN
    store(3'b010, 32'h0000_0041, 32'hDEAD_BEEF);
    check("mis_sw_err",   32'(sq.st_err),  32'd1);
    check("mis_sw_no_we", 32'(sq.dmem_we), 32'd0);
    store(3'b001, 32'h0000_0203, 32'h0000_BEEF);
    check("mis_sh_err",   32'(sq.st_err),  32'd1);
    check("mis_sh_no_we", 32'(sq.dmem_we), 32'd0);
    tick();
`else
    push_exp(32'h0000_0040, 4'b1111, 32'hDEAD_BEEF);
    push_exp(32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    store(3'b010, 32'h0000_0041, 32'hDEAD_BEEF);
    check("mis_sw_no_err", 32'(sq.st_err), 32'd0);
    store(3'b001, 32'h0000_0203, 32'h0000_BEEF);
    check("mis_sh_no_err", 32'(sq.st_err), 32'd0);
    wait_drain("drain_misaligned");
`endif

    // Reset mid-drain discards the remaining entry
    sq.ld_valid = 1'b1;
    sq.ld_addr  = 32'h0000_0900;
    push_exp(32'h0000_0070, 4'b1111, 32'h7070_7070);
    store(3'b010, 32'h0000_0070, 32'h7070_7070);
    store(3'b010, 32'h0000_0074, 32'h7474_7474);
    sq.ld_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_we",    32'(sq.dmem_we),  32'd0);
    check("post_rst_ready", 32'(sq.st_ready), 32'd1);
    repeat (4) tick();
    check("post_rst_quiet", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_queue_ctrl.md
STORE_QUEUE_CTRL -- requirements
Module: store_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of store-queue entries (power of two, 2..8).
REQ-002 SHALL have ports: clk in 1 system clock; rst in 1 reset; the design has one clock, and reset is synchronous and active-high.
REQ-003 SHALL have ports: st_valid in 1 MEM-stage store request; st_funct3 in 3 store width (000 SB, 001 SH, 010 SW); st_addr in 32 byte address; st_data in 32 rs2 value; st_ready out 1 store accepted, 0 = stall pipeline.
REQ-004 SHALL have ports: ld_valid in 1 MEM-stage load; ld_addr in 32 load byte address; ld_hazard out 1 load overlaps a queued store word, stall pipeline.
REQ-005 SHALL have ports: flush_req in 1 fence/drain request; flush_done out 1 one-cycle pulse, queue empty after flush.
REQ-006 SHALL have ports: dmem_we out 1 write strobe; dmem_be out 4 byte enables; dmem_addr out 32 word-aligned address; dmem_wdata out 32 lane-replicated data; st_err out 1 one-cycle pulse for a rejected store.

Function
REQ-007 SHALL accept a store at posedge clk when st_valid && st_ready, pushing {word addr, be, wdata} at the tail.
REQ-008 SHALL format SB as be = 4'b0001 << addr[1:0] and wdata = {4{data[7:0]}}.
REQ-009 SHALL format SH as be = 4'b0011 << {addr[1],1'b0} and wdata = {2{data[15:0]}}; SW as be = 4'b1111 and wdata = data.
REQ-010 SHALL consume a store with any other st_funct3 without enqueuing it and pulse st_err the following cycle.
REQ-011 SHALL drive st_ready = (count < DEPTH) && (state != FLUSH), combinationally.
REQ-012 SHALL give the memory port to the load when ld_valid && !ld_hazard; otherwise, with the queue non-empty, SHALL drain the head entry.
REQ-013 SHALL drive dmem_we, dmem_be and dmem_wdata from the head entry during a drain cycle and pop that entry at the same posedge; during a load cycle dmem_we = 0 and dmem_addr = {ld_addr[31:2],2'b00}.
REQ-014 SHALL drive ld_hazard = ld_valid && any valid entry with addr[31:2] == ld_addr[31:2], combinationally.
REQ-015 SHALL allow push and pop in the same cycle; count is unchanged and the queue order is preserved.
REQ-016 SHALL use wrapping head and tail pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; it SHALL never overflow or underflow.
REQ-017 SHALL implement these FSM states: IDLE (empty), ACTIVE (non-empty), FLUSH (draining, no accept).
REQ-018 SHALL make these transitions: IDLE->ACTIVE on push; ACTIVE->IDLE when the last entry pops with no push; IDLE/ACTIVE->FLUSH on flush_req.
REQ-019 SHALL, in FLUSH, drain regardless of ld_valid, then go FLUSH->IDLE and pulse flush_done when count reaches 0.
REQ-020 SHALL pulse flush_done the next cycle when flush_req arrives with the queue empty.

Reset
REQ-021 SHALL, on rst high at posedge clk, clear count and pointers, set state IDLE, and clear flush_done and st_err.
REQ-022 SHALL discard all queued stores when reset is applied mid-drain; dmem_we SHALL be 0 in the cycle following reset.

Configuration
REQ-023 SHALL, with STORE_MISALIGN_TRAP_EN defined, reject SH with addr[0]=1 and SW with addr[1:0]!=0: no enqueue, st_err pulse.
REQ-024 SHALL, with STORE_MISALIGN_TRAP_EN undefined, force alignment by ignoring addr[0] for SH and addr[1:0] for SW, with st_err only for illegal funct3.

Structure
REQ-025 SHALL place the funct3 encodings (SB/SH/SW), the state enum and the queue-entry struct typedef in shared package riscv_mem_pkg.
REQ-026 SHALL implement lane formatting (REQ-008..010) in sub-module store_lane_fmt, purely combinational and instantiated once.

Verification
REQ-027 SHALL cover: SB addr 0x103, data 0xAABBCCDD -> dmem_be 1000, dmem_wdata 0xDDDDDDDD, dmem_addr 0x100.
REQ-028 SHALL cover: SH addr 0x202, data 0x1234 -> dmem_be 1100, dmem_wdata 0x12341234.
REQ-029 SHALL cover: DEPTH=2, two stores with ld_valid held and no hazard -> st_ready 0 on a third store; after ld_valid drops, two drain cycles in order.
REQ-030 SHALL cover: SW queued at 0x40, then load at 0x42 -> ld_hazard 1 until the drain cycle, then 0.
REQ-031 SHALL cover: flush_req with 2 entries -> st_ready 0, two writes, flush_done pulse on the cycle after the last pop.
REQ-032 SHALL cover: SW at 0x41 with the macro defined -> st_err pulse, no write; with the macro undefined -> write to 0x40, be 1111.
